// File: rtl/median_pkg.sv
// Shared definitions for the median filter pipeline and its border mask stage.
// The packed stream layout matches the tx_* bundle of the 5x5 median stage.
package median_pkg;

  localparam int PIX_W  = 8;
  localparam int CNT_W_DEF  = 12;
  localparam int BORDER_DEF = 2;
  localparam logic [3*PIX_W-1:0] FILL_RGB_DEF = 24'h000000;

  // 27-bit video word {dv, vs, hs, r, g, b}
  typedef struct packed {
    logic             dv;
    logic             vs;
    logic             hs;
    logic [PIX_W-1:0] r;
    logic [PIX_W-1:0] g;
    logic [PIX_W-1:0] b;
  } stream_t;

endpackage

// File: rtl/video_pos_counter.sv
// Pixel position tracking and per-frame active-size measurement.
// Optional build macro MEDIAN_BORDER_STATS_EN adds frame/error counters.
// pos_x/pos_y describe the pixel presented this cycle; a frame-start edge
// forces them to zero so that pixel becomes the origin of the new frame.
module video_pos_counter
  import median_pkg::*;
#(
  parameter int BORDER = BORDER_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  parameter bit VS_POL = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_dv,
  input  logic             in_vs,
  output logic [CNT_W-1:0] pos_x,
  output logic [CNT_W-1:0] pos_y,
  output logic [CNT_W-1:0] act_width,
  output logic [CNT_W-1:0] act_height,
  output logic             meas_valid
`ifdef MEDIAN_BORDER_STATS_EN
  ,
  output logic [15:0]      frame_cnt,
  output logic [15:0]      err_cnt
`endif
);

  localparam logic [CNT_W-1:0] MIN_SIZE = CNT_W'(2 * BORDER + 1);

  logic [CNT_W-1:0] x_reg, y_reg, line_len_reg, first_len_reg;
  logic [CNT_W-1:0] act_width_reg, act_height_reg;
  logic             mismatch_reg, chk_reg, skip_reg, partial_reg;
  logic             meas_valid_reg, dv_prev_reg, vs_prev_reg;

  logic             vs_edge, dv_fall, mismatch_now, size_ok;
  logic [CNT_W-1:0] x_inc, y_inc;

  assign vs_edge = (in_vs == VS_POL) && !vs_prev_reg;
  assign dv_fall = !in_dv && dv_prev_reg;
  // A line-length check can still be pending one cycle after the line end.
  assign mismatch_now = mismatch_reg || (chk_reg && (line_len_reg != first_len_reg));
  assign size_ok = (y_reg >= MIN_SIZE) && (first_len_reg >= MIN_SIZE);
  assign x_inc = (x_reg == '1) ? x_reg : x_reg + 1'b1;
  assign y_inc = (y_reg == '1) ? y_reg : y_reg + 1'b1;

  assign pos_x      = vs_edge ? '0 : x_reg;
  assign pos_y      = vs_edge ? '0 : y_reg;
  assign act_width  = act_width_reg;
  assign act_height = act_height_reg;
  assign meas_valid = meas_valid_reg;

  // Position counters, line bookkeeping and frame-start measurement latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_reg          <= '0;
      y_reg          <= '0;
      line_len_reg   <= '0;
      first_len_reg  <= '0;
      act_width_reg  <= '0;
      act_height_reg <= '0;
      mismatch_reg   <= 1'b0;
      chk_reg        <= 1'b0;
      skip_reg       <= 1'b0;
      partial_reg    <= 1'b1;
      meas_valid_reg <= 1'b0;
      dv_prev_reg    <= 1'b0;
      vs_prev_reg    <= 1'b0;
    end else begin
      dv_prev_reg <= in_dv;
      vs_prev_reg <= (in_vs == VS_POL);
      if (vs_edge) begin
        if (y_reg != '0) begin
          act_height_reg <= y_reg;
          act_width_reg  <= first_len_reg;
        end
        meas_valid_reg <= !partial_reg && !mismatch_now && size_ok;
        y_reg          <= '0;
        first_len_reg  <= '0;
        mismatch_reg   <= 1'b0;
        chk_reg        <= 1'b0;
        partial_reg    <= 1'b0;
        x_reg          <= {{(CNT_W-1){1'b0}}, in_dv};
        // A line already running when vs hits is truncated and never counted.
        skip_reg       <= in_dv && dv_prev_reg;
      end else if (dv_fall) begin
        x_reg        <= '0;
        skip_reg     <= 1'b0;
        mismatch_reg <= mismatch_now;
        chk_reg      <= !skip_reg && (y_reg != '0);
        if (!skip_reg) begin
          line_len_reg <= x_reg;
          y_reg        <= y_inc;
          if (y_reg == '0) first_len_reg <= x_reg;
        end
      end else begin
        if (in_dv) x_reg <= x_inc;
        mismatch_reg <= mismatch_now;
        chk_reg      <= 1'b0;
      end
    end
  end

`ifdef MEDIAN_BORDER_STATS_EN
  logic [15:0] frame_cnt_reg, err_cnt_reg;

  assign frame_cnt = frame_cnt_reg;
  assign err_cnt   = err_cnt_reg;

  // Count frames and frames whose measurement failed consistency or size checks.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_reg <= '0;
      err_cnt_reg   <= '0;
    end else if (vs_edge) begin
      frame_cnt_reg <= frame_cnt_reg + 16'd1;
      if (mismatch_now || !size_ok) err_cnt_reg <= err_cnt_reg + 16'd1;
    end
  end
`endif

endmodule

// File: rtl/median_border_mask.sv
// Border mask after the 5x5 median stage: replaces the BORDER-wide frame edge
// with a fill colour and registers the whole stream by one clock.
// Optional build macro MEDIAN_BORDER_STATS_EN adds frame_cnt/err_cnt outputs.
module median_border_mask
  import median_pkg::*;
#(
  parameter int                  BORDER   = BORDER_DEF,
  parameter int                  CNT_W    = CNT_W_DEF,
  parameter logic [3*PIX_W-1:0]  FILL_RGB = FILL_RGB_DEF,
  parameter bit                  VS_POL   = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_dv,
  input  logic             in_hs,
  input  logic             in_vs,
  input  logic [7:0]       in_red,
  input  logic [7:0]       in_green,
  input  logic [7:0]       in_blue,
  input  logic             bypass,
  output logic             out_dv,
  output logic             out_hs,
  output logic             out_vs,
  output logic [7:0]       out_red,
  output logic [7:0]       out_green,
  output logic [7:0]       out_blue,
  output logic [CNT_W-1:0] act_width,
  output logic [CNT_W-1:0] act_height,
  output logic             meas_valid
`ifdef MEDIAN_BORDER_STATS_EN
  ,
  output logic [15:0]      frame_cnt,
  output logic [15:0]      err_cnt
`endif
);

  localparam logic [CNT_W-1:0] BORDER_V = CNT_W'(BORDER);

  logic [CNT_W-1:0] pos_x, pos_y;
  logic             mask_lt, mask_rb, fill_en;
  stream_t          in_s, out_next, out_reg;

  video_pos_counter #(
    .BORDER (BORDER),
    .CNT_W  (CNT_W),
    .VS_POL (VS_POL)
  ) u_pos (
    .clk        (clk),
    .rst        (rst),
    .in_dv      (in_dv),
    .in_vs      (in_vs),
    .pos_x      (pos_x),
    .pos_y      (pos_y),
    .act_width  (act_width),
    .act_height (act_height),
    .meas_valid (meas_valid)
`ifdef MEDIAN_BORDER_STATS_EN
    ,
    .frame_cnt  (frame_cnt),
    .err_cnt    (err_cnt)
`endif
  );

  // Left/top edges are always known; right/bottom rely on last frame's size,
  // which is only trusted (and large enough to subtract from) when meas_valid.
  assign mask_lt = (pos_x < BORDER_V) || (pos_y < BORDER_V);
  assign mask_rb = meas_valid &&
                   ((pos_x >= act_width - BORDER_V) || (pos_y >= act_height - BORDER_V));
  assign fill_en = in_dv && (mask_lt || mask_rb) && !bypass;

  assign in_s     = {in_dv, in_vs, in_hs, in_red, in_green, in_blue};
  assign out_next = fill_en ? {in_dv, in_vs, in_hs, FILL_RGB} : in_s;

  // Single output register stage; sync bits only ever pass through.
  always_ff @(posedge clk) begin
    if (rst) out_reg <= '0;
    else     out_reg <= out_next;
  end

  assign out_dv    = out_reg.dv;
  assign out_hs    = out_reg.hs;
  assign out_vs    = out_reg.vs;
  assign out_red   = out_reg.r;
  assign out_green = out_reg.g;
  assign out_blue  = out_reg.b;

endmodule

// File: tb/tb_median_border_mask.sv
// Self-checking bench for median_border_mask: frame-level stimulus table plus
// randomized frames, checked against a frame/pixel reference model.
module tb_median_border_mask;

  localparam logic [23:0] FILL = 24'hA5C3E1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_dv = 1'b0, in_hs = 1'b0, in_vs = 1'b0, bypass = 1'b0;
  logic [7:0]  in_red = 8'd0, in_green = 8'd0, in_blue = 8'd0;
  logic        out_dv, out_hs, out_vs, meas_valid;
  logic [7:0]  out_red, out_green, out_blue;
  logic [11:0] act_width, act_height;
`ifdef MEDIAN_BORDER_STATS_EN
  logic [15:0] frame_cnt, err_cnt;
`endif

  always #5 clk = ~clk;

  median_border_mask #(
    .BORDER(2), .CNT_W(12), .FILL_RGB(FILL), .VS_POL(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .in_dv(in_dv), .in_hs(in_hs), .in_vs(in_vs),
    .in_red(in_red), .in_green(in_green), .in_blue(in_blue), .bypass(bypass),
    .out_dv(out_dv), .out_hs(out_hs), .out_vs(out_vs),
    .out_red(out_red), .out_green(out_green), .out_blue(out_blue),
    .act_width(act_width), .act_height(act_height), .meas_valid(meas_valid)
`ifdef MEDIAN_BORDER_STATS_EN
    , .frame_cnt(frame_cnt), .err_cnt(err_cnt)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc_no  = 0;

  // Reference model: measurement of the previous frame, from recorded line lengths.
  int m_aw = 0, m_ah = 0;
  bit m_mv = 1'b0, m_partial = 1'b1, meas_chk = 1'b0, byp_cur = 1'b0;
  int lens[$];

  function automatic bit mask_of(int c, int r);
    return (c < 2) || (r < 2) || (m_mv && ((c >= m_aw - 2) || (r >= m_ah - 2)));
  endfunction

  task automatic model_frame_start();
    bit ok;
    ok = !m_partial && (lens.size() >= 5) && (lens[0] >= 5);
    if (lens.size() > 0) begin
      m_ah = lens.size();
      m_aw = lens[0];
      foreach (lens[i]) if (lens[i] != lens[0]) ok = 1'b0;
    end
    m_mv = ok;
    lens.delete();
    m_partial = 1'b0;
    meas_chk = 1'b1;
  endtask

  task automatic model_reset();
    m_aw = 0; m_ah = 0; m_mv = 1'b0; m_partial = 1'b1;
    lens.delete();
    meas_chk = 1'b0;
  endtask

  task automatic check_meas(input string name, input int aw, input int ah, input bit mv);
    n_tests++;
    if (act_width !== 12'(aw) || act_height !== 12'(ah) || meas_valid !== mv) begin
      n_fail++;
      $display("FAIL %s: got w=%0d h=%0d valid=%0b, expected w=%0d h=%0d valid=%0b",
               name, act_width, act_height, meas_valid, aw, ah, mv);
    end
  endtask

  // One clock: drive at negedge, compare registered outputs just after posedge.
  task automatic cyc(input logic dv, input logic hs, input logic vs,
                     input bit fill, input bit do_rst);
    logic [23:0] rgb;
    logic [26:0] exp_o, got_o;
    rgb = 24'($urandom);
    @(negedge clk);
    rst = do_rst; in_dv = dv; in_hs = hs; in_vs = vs; bypass = byp_cur;
    {in_red, in_green, in_blue} = rgb;
    @(posedge clk);
    #1;
    cyc_no++;
    if (do_rst) exp_o = '0;
    else        exp_o = {dv, vs, hs, (dv && fill && !byp_cur) ? FILL : rgb};
    got_o = {out_dv, out_vs, out_hs, out_red, out_green, out_blue};
    n_tests++;
    if (got_o !== exp_o) begin
      n_fail++;
      $display("FAIL stream cyc=%0d {dv,vs,hs,rgb}: got=%h expected=%h", cyc_no, got_o, exp_o);
    end
    if (do_rst) check_meas("reset_meas", 0, 0, 1'b0);
    else if (meas_chk) begin
      check_meas("edge_meas", m_aw, m_ah, m_mv);
      meas_chk = 1'b0;
    end
  endtask

  // One frame: vs pulse (or vs on the first pixel), then h lines with hblank.
  task automatic run_frame(input int w, input int h, input int bad_line, input int bad_len,
                           input bit byp, input bit sync_dv, input int rst_row, input int rst_col);
    int len, col_base, row_base;
    byp_cur = byp;
    row_base = 0;
    if (!sync_dv) begin
      model_frame_start();
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    for (int r = 0; r < h; r++) begin
      len = (r == bad_line) ? bad_len : w;
      col_base = 0;
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int c = 0; c < len; c++) begin
        logic v;
        v = sync_dv && (r == 0) && (c < 2);
        if (sync_dv && r == 0 && c == 0) model_frame_start();
        if (r == rst_row && c == rst_col) begin
          model_reset();
          row_base = r;
          col_base = c + 1;
          cyc(1'b1, 1'b0, v, 1'b0, 1'b1);
        end else begin
          cyc(1'b1, 1'b0, v, mask_of(c - col_base, r - row_base), 1'b0);
        end
      end
      if (len - col_base > 0) lens.push_back(len - col_base);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  typedef struct {
    int w; int h; int bad_line; int bad_len;
    bit byp; bit sync_dv; int rst_row; int rst_col;
    int exp_aw; int exp_ah; bit exp_mv;   // measurement outputs at end of frame
  } frame_vec_t;

  frame_vec_t tbl[15];

  initial begin
    tbl[0]  = '{16, 10, -1, 0,  1'b0, 1'b0, -1, 0,  0,  0, 1'b0};
    tbl[1]  = '{16, 10, -1, 0,  1'b0, 1'b0, -1, 0, 16, 10, 1'b1};
    tbl[2]  = '{16, 10, -1, 0,  1'b0, 1'b0, -1, 0, 16, 10, 1'b1};
    tbl[3]  = '{16, 10, -1, 0,  1'b1, 1'b0, -1, 0, 16, 10, 1'b1};
    tbl[4]  = '{16, 10,  4, 15, 1'b0, 1'b0, -1, 0, 16, 10, 1'b1};
    tbl[5]  = '{16, 10, -1, 0,  1'b0, 1'b0, -1, 0, 16, 10, 1'b0};
    tbl[6]  = '{4,  4,  -1, 0,  1'b0, 1'b0, -1, 0, 16, 10, 1'b1};
    tbl[7]  = '{16, 10, -1, 0,  1'b0, 1'b0, -1, 0,  4,  4, 1'b0};
    tbl[8]  = '{12, 7,  -1, 0,  1'b0, 1'b0, -1, 0, 16, 10, 1'b1};
    tbl[9]  = '{12, 7,  -1, 0,  1'b0, 1'b0, -1, 0, 12,  7, 1'b1};
    tbl[10] = '{16, 10, -1, 0,  1'b0, 1'b1, -1, 0, 12,  7, 1'b1};
    tbl[11] = '{16, 10, -1, 0,  1'b0, 1'b0, -1, 0, 16, 10, 1'b1};
    tbl[12] = '{16, 10, -1, 0,  1'b0, 1'b0,  3, 5,  0,  0, 1'b0};
    tbl[13] = '{16, 10, -1, 0,  1'b0, 1'b0, -1, 0, 10,  7, 1'b0};
    tbl[14] = '{16, 10, -1, 0,  1'b0, 1'b0, -1, 0, 16, 10, 1'b1};

    model_reset();
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    foreach (tbl[i]) begin
      run_frame(tbl[i].w, tbl[i].h, tbl[i].bad_line, tbl[i].bad_len,
                tbl[i].byp, tbl[i].sync_dv, tbl[i].rst_row, tbl[i].rst_col);
      check_meas($sformatf("frame%0d_meas", i), tbl[i].exp_aw, tbl[i].exp_ah, tbl[i].exp_mv);
    end

    for (int k = 0; k < 6; k++) begin
      int w, h, bl;
      w  = int'($urandom_range(5, 20));
      h  = int'($urandom_range(5, 12));
      bl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, h - 1)) : -1;
      run_frame(w, h, bl, w + 1, 1'($urandom_range(0, 1)), 1'b0, -1, 0);
    end
    run_frame(16, 10, -1, 0, 1'b0, 1'b0, -1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
